// File: rtl/sevenseg_pkg.sv
// Shared definitions for the three-digit 7-segment scan controller.
package sevenseg_pkg;

  // One-cold, active-low digit enables.
  localparam logic [2:0] EN_DIG0 = 3'b110;
  localparam logic [2:0] EN_DIG1 = 3'b101;
  localparam logic [2:0] EN_DIG2 = 3'b011;
  localparam logic [2:0] EN_OFF  = 3'b111;

  // Slot index: 0 = rightmost digit, 2 = leftmost digit.
  typedef logic [1:0] slot_t;

  // Per-slot phase: all digits dark, then the slot's digit lit.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Nibble of the 12-bit display value belonging to a slot.
  function automatic logic [3:0] pick_nibble(input logic [11:0] value, input slot_t slot);
    logic [3:0] nib;
    case (slot)
      2'd0:    nib = value[3:0];
      2'd1:    nib = value[7:4];
      2'd2:    nib = value[11:8];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  // Decimal-point bit belonging to a slot.
  function automatic logic pick_dp(input logic [2:0] dp, input slot_t slot);
    logic bit_v;
    case (slot)
      2'd0:    bit_v = dp[0];
      2'd1:    bit_v = dp[1];
      2'd2:    bit_v = dp[2];
      default: bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

  // Active-low enable code for a slot.
  function automatic logic [2:0] slot_enable(input slot_t slot);
    logic [2:0] en;
    case (slot)
      2'd0:    en = EN_DIG0;
      2'd1:    en = EN_DIG1;
      2'd2:    en = EN_DIG2;
      default: en = EN_OFF;
    endcase
    return en;
  endfunction

  // Leading-zero suppression: digit2 dark if it is zero, digit1 dark if
  // both digit2 and digit1 are zero; digit0 always shown.
  function automatic logic slot_suppressed(input logic [11:0] value, input logic lzb,
                                           input slot_t slot);
    logic sup;
    sup = 1'b0;
    if (lzb) begin
      case (slot)
        2'd2:    sup = (value[11:8] == 4'h0);
        2'd1:    sup = (value[11:8] == 4'h0) && (value[7:4] == 4'h0);
        default: sup = 1'b0;
      endcase
    end
    return sup;
  endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// Slot/digit scan counters. Outputs are look-ahead: they describe the
// values the counters take at the coming edge, so the top level can
// register its display outputs in the same edge without a cycle of lag.
module sevenseg_scan_timer
  import sevenseg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned CNT_W     = $clog2(SCAN_DIV)
) (
  input  logic  clk,
  input  logic  rst,
  output slot_t slot,
  output logic  in_blank,
  output logic  wrap_frame
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_t            slot_q, slot_d;
  scan_state_e      state_d;
  logic             wrap_slot;

  // Next counter values, slot advance and blank/show phase.
  always_comb begin
    wrap_slot = (cnt_q == CNT_LAST);
    cnt_d     = wrap_slot ? '0 : cnt_q + 1'b1;
    slot_d    = slot_q;
    if (wrap_slot) begin
      slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
    end
    state_d    = (cnt_d < BLANK_LIM) ? BLANK : SHOW;
    slot       = slot_d;
    in_blank   = (state_d == BLANK);
    wrap_frame = wrap_slot && (slot_q == 2'd2);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= 2'd0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/sevenseg_scan3.sv
// Three-digit scan controller: captures a display value, hands it to the
// display at frame boundaries and time-multiplexes it onto one decoder.
module sevenseg_scan3
  import sevenseg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned CNT_W     = $clog2(SCAN_DIV)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] digits_in,
  input  logic [2:0]  dp_in,
  input  logic        lzb_en,
  output logic        load_ack,
  output logic [3:0]  digit_code,
  output logic        dp_n,
  output logic [2:0]  SevenSegmentEnable,
  output logic        frame_tick
);

  slot_t slot_nx;
  logic  blank_nx;
  logic  wrap_frame;

  sevenseg_scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .slot       (slot_nx),
    .in_blank   (blank_nx),
    .wrap_frame (wrap_frame)
  );

  logic [11:0] pend_val_q, pend_val_d;
  logic [2:0]  pend_dp_q, pend_dp_d;
  logic        pend_lzb_q, pend_lzb_d;
  logic        pend_valid_q, pend_valid_d;
  logic [11:0] shadow_val_q, shadow_val_d;
  logic [2:0]  shadow_dp_q, shadow_dp_d;
  logic        shadow_lzb_q, shadow_lzb_d;
  logic        load_ack_q, load_ack_d;
  logic        frame_tick_q, frame_tick_d;
  logic [3:0]  digit_code_q, digit_code_d;
  logic        dp_n_q, dp_n_d;
  logic [2:0]  en_q, en_d;
  logic        lit;

  // Capture into pending, frame-synchronous transfer to shadow, and output muxing.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_lzb_d   = pend_lzb_q;
    pend_valid_d = pend_valid_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_lzb_d = shadow_lzb_q;

    if (load) begin
      pend_val_d = digits_in;
      pend_dp_d  = dp_in;
      pend_lzb_d = lzb_en;
    end

    // A load landing on the transfer edge bypasses pending entirely.
    if (wrap_frame) begin
      pend_valid_d = 1'b0;
      if (load) begin
        shadow_val_d = digits_in;
        shadow_dp_d  = dp_in;
        shadow_lzb_d = lzb_en;
      end else if (pend_valid_q) begin
        shadow_val_d = pend_val_q;
        shadow_dp_d  = pend_dp_q;
        shadow_lzb_d = pend_lzb_q;
      end
    end else if (load) begin
      pend_valid_d = 1'b1;
    end

    // Outputs are computed from next-edge state so the registers show it directly.
    lit          = !blank_nx && !slot_suppressed(shadow_val_d, shadow_lzb_d, slot_nx);
    en_d         = lit ? slot_enable(slot_nx) : EN_OFF;
    dp_n_d       = lit ? ~pick_dp(shadow_dp_d, slot_nx) : 1'b1;
    digit_code_d = pick_nibble(shadow_val_d, slot_nx);
    load_ack_d   = load;
    frame_tick_d = wrap_frame;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_lzb_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      shadow_lzb_q <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      digit_code_q <= '0;
      dp_n_q       <= 1'b1;
      en_q         <= EN_OFF;
    end else begin
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_lzb_q   <= pend_lzb_d;
      pend_valid_q <= pend_valid_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_lzb_q <= shadow_lzb_d;
      load_ack_q   <= load_ack_d;
      frame_tick_q <= frame_tick_d;
      digit_code_q <= digit_code_d;
      dp_n_q       <= dp_n_d;
      en_q         <= en_d;
    end
  end

  assign load_ack           = load_ack_q;
  assign frame_tick         = frame_tick_q;
  assign digit_code         = digit_code_q;
  assign dp_n               = dp_n_q;
  assign SevenSegmentEnable = en_q;

endmodule

// File: doc/sevenseg_scan3.md
Name: sevenseg_scan3

Overview:
- Three-digit display scan controller that sits directly upstream of the 7-segment decoder.
- Holds a 12-bit BCD/hex display value and time-multiplexes it onto one decoder.
- Each cycle it presents one 4-bit digit code on the decoder's input and drives the matching active-low digit enable.
- Provides a load/ack capture path, frame-synchronous display update, an anti-ghost blanking interval per digit, and optional leading-zero blanking.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (blank plus show); must be ≥ 2.
- BLANK_CYC, 500, cycles at the start of each slot with all digits off; must satisfy 0 ≤ BLANK_CYC < SCAN_DIV.
- CNT_W, $clog2(SCAN_DIV), width of the slot counter (derived; do not override).

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle request to capture digits_in, dp_in and lzb_en.
- digits_in  in  12  [3:0] is digit0 (rightmost), [7:4] is digit1, [11:8] is digit2.
- dp_in  in  3  decimal point per digit, active-high, bit i maps to digit i.
- lzb_en  in  1  leading-zero blanking enable.
- load_ack  out  1  one-cycle pulse, the cycle after a load is captured.
- digit_code  out  4  nibble for the current slot; feeds the decoder's 4-bit input.
- dp_n  out  1  decimal point, active-low.
- SevenSegmentEnable  out  3  one-cold active-low digit enables: 110 = digit0, 101 = digit1, 011 = digit2, 111 = off.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - SevenSegmentEnable = 111, digit_code = 0, dp_n = 1, load_ack = 0, frame_tick = 0.
  - slot = 0, cnt = 0, state = BLANK.
  - Shadow registers (value, dp, lzb) = 0; pending_valid = 0.
- Capture path:
  - load=1 at an edge writes digits_in, dp_in and lzb_en into the pending registers and sets pending_valid.
  - load_ack is 1 in the following cycle.
  - A second load before the transfer overwrites pending; the last load wins.
- Transfer:
  - The transfer cycle is the edge where slot wraps 2→0 (cnt = SCAN_DIV-1 and slot = 2).
  - If pending_valid is set at that edge, pending is copied to the shadow registers and pending_valid is cleared.
  - If load=1 on the transfer edge, the incoming data goes straight to shadow, pending_valid ends at 0, and load_ack still pulses.
  - frame_tick pulses in the cycle after the transfer edge.
- Scan counter:
  - cnt counts 0..SCAN_DIV-1, then wraps to 0 and advances slot 0→1→2→0.
- States:
  - BLANK while cnt < BLANK_CYC; SHOW otherwise.
  - If BLANK_CYC = 0, the BLANK state is never entered.
- Outputs (all registered, reflecting the state after each edge):
  - digit_code = shadow nibble[slot] for the whole slot, including blank, so the decoder settles before enable.
  - SevenSegmentEnable = 111 in BLANK.
  - In SHOW it is the slot's one-cold code, unless that slot is suppressed, in which case it stays 111.
  - dp_n = ~shadow_dp[slot] in SHOW, 1 otherwise.
- Leading-zero suppression (only when shadow lzb = 1):
  - digit2 is suppressed if nibble2 = 0.
  - digit1 is suppressed if nibble2 = 0 and nibble1 = 0.
  - digit0 is never suppressed.
  - A suppressed slot with shadow dp = 1 still shows nothing; suppression wins.
- Reset mid-slot: outputs return to their reset values immediately; the scan restarts at slot 0 in BLANK.

Decomposition:
- Shared package sevenseg_pkg holds:
  - EN_DIG0 = 3'b110, EN_DIG1 = 3'b101, EN_DIG2 = 3'b011, EN_OFF = 3'b111.
  - Slot index type (2 bits) and state enum {BLANK, SHOW}.
- One natural sub-module, sevenseg_scan_timer:
  - Holds the cnt/slot counters.
  - Outputs slot, in_blank and wrap_frame.
- Capture, shadow and output muxing stay in the top level.

Test Plan (SCAN_DIV = 8, BLANK_CYC = 2):
- Reset, then release:
  - Outputs are 111 / 0 / 1 during reset.
  - After release: 2 cycles at 111, then 6 cycles at 110 with code 0, then 2 cycles at 111, then 101.
- load 12'h3A7 mid-frame:
  - load_ack high the next cycle.
  - Display unchanged until frame_tick.
  - Next frame shows code 7 at 110, A at 101, 3 at 011.
- lzb_en = 1:
  - 12'h005: only 110 with code 5 is enabled; slots 1 and 2 stay 111.
  - 12'h050: slot1 shows 5, slot0 shows 0, slot2 is off.
  - 12'h000: only slot0 shows 0.
- Loads of 12'h111 then 12'h222 within one frame: the next frame shows 222; 111 is never displayed.
- load 12'h456 on the transfer edge: the frame starting there shows 6, 5, 4; pending_valid ends at 0.
- dp_in = 3'b010 with rst pulsed mid-SHOW:
  - dp_n = 0 only in the SHOW phase of slot1.
  - On the rst pulse, enable goes to 111 asynchronously and the scan restarts at slot0 BLANK.
